// File: rtl/search_pkg.sv
// Shared types and constants for the nearest-vertex search controller.
// Holds the FSM state type, default vector geometry and the "no result yet" distance.
package search_pkg;

  localparam int unsigned DefDim   = 9;
  localparam int unsigned DefWidth = 32;

  // Sliced to WIDTH by users; supports distance widths up to 64 bits.
  localparam logic [63:0] DistAllOnes = '1;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/nearest_search_ctrl_dist.sv
// Squared Euclidean distance unit: accumulates (v-q)^2 as one dimension arrives per strobe,
// and presents the total one cycle after the last dimension (DIM-1) is delivered.
module nearest_search_ctrl_dist
  import search_pkg::*;
#(
  parameter int unsigned DIM   = DefDim,
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [DIM-1:0]            data_valid_in,
  input  logic [DIM-1:0][WIDTH-1:0] vertex_pos_in,
  input  logic [DIM-1:0][WIDTH-1:0] query_pos_in,
  output logic                      data_valid_out,
  output logic [WIDTH-1:0]          dist_out
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dist_q, dist_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] sel_v, sel_q, diff, term, sum;

  // Strobes are one-hot, so OR-selecting the active dimension needs only one multiplier.
  always_comb begin
    sel_v = '0;
    sel_q = '0;
    for (int d = 0; d < DIM; d++) begin
      if (data_valid_in[d]) begin
        sel_v = sel_v | vertex_pos_in[d];
        sel_q = sel_q | query_pos_in[d];
      end
    end
    diff = (sel_v > sel_q) ? (sel_v - sel_q) : (sel_q - sel_v);
    term = diff * diff;
    sum  = acc_q + term;
  end

  always_comb begin
    acc_d  = acc_q;
    dist_d = dist_q;
    vld_d  = 1'b0;
    if (|data_valid_in) begin
      if (data_valid_in[DIM-1]) begin
        dist_d = sum;
        vld_d  = 1'b1;
        acc_d  = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc_q  <= '0;
      dist_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dist_q <= dist_d;
      vld_q  <= vld_d;
    end
  end

  assign data_valid_out = vld_q;
  assign dist_out       = dist_q;

endmodule

// File: rtl/nearest_search_ctrl.sv
// Nearest-vertex search: streams each candidate vertex from memory into the distance unit,
// one vertex in flight at a time, and keeps the minimum squared distance and its index.
module nearest_search_ctrl
  import search_pkg::*;
#(
  parameter int unsigned DIM     = DefDim,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [ADDR_W-1:0]         cand_base_in,
  input  logic [CNT_W-1:0]          cand_count_in,
  input  logic [DIM-1:0][WIDTH-1:0] query_pos_in,
  output logic                      mem_rd_out,
  output logic [ADDR_W-1:0]         mem_addr_out,
  input  logic [WIDTH-1:0]          mem_data_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      found_out,
  output logic [WIDTH-1:0]          best_dist_out,
  output logic [CNT_W-1:0]          best_idx_out,
  output logic                      error_out
);

  localparam int unsigned DimW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  // Assert asynchronously, release on the next edge so logic leaves reset cleanly.
  logic rst_sync_q;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rst_sync_q <= 1'b0;
    else         rst_sync_q <= 1'b1;
  end

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            best_idx_q, best_idx_d;
  logic [WIDTH-1:0]            best_dist_q, best_dist_d;
  logic [DimW-1:0]             dim_q, dim_d;
  logic [TmrW-1:0]             tmr_q, tmr_d;
  logic                        found_q, found_d;
  logic                        error_q, error_d;
  logic [MEM_LAT-1:0]          pvld_q, pvld_d;
  logic [MEM_LAT-1:0][DimW-1:0] pdim_q, pdim_d;

  logic                        dist_valid;
  logic [WIDTH-1:0]            dist_val;
  logic [DIM-1:0]              dv_in;
  logic [DIM-1:0][WIDTH-1:0]   vpos_in;
  logic                        last_cand;
  logic                        dim_last;
  logic                        tmr_expired;

  assign last_cand   = ({1'b0, idx_q} + (CNT_W + 1)'(1)) >= {1'b0, count_q};
  assign dim_last    = (dim_q == DimW'(DIM - 1));
  assign tmr_expired = (tmr_q == TmrW'(TIMEOUT - 1));

  always_ff @(posedge clk_in or negedge rst_sync_q) begin
    if (!rst_sync_q) state_q <= StIdle;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_in) state_d = (cand_count_in == '0) ? StDone : StFetch;
      StFetch: if (dim_last) state_d = StDrain;
      StDrain: begin
        if (dist_valid)       state_d = last_cand ? StDone : StFetch;
        else if (tmr_expired) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_rd_out = (state_q == StFetch);
    busy_out   = (state_q != StIdle);
    done_out   = (state_q == StDone);
  end

  always_comb begin
    addr_d      = addr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    best_idx_d  = best_idx_q;
    best_dist_d = best_dist_q;
    dim_d       = dim_q;
    tmr_d       = tmr_q;
    found_d     = found_q;
    error_d     = error_q;
    // Tag each read with its dimension and delay it to line up with the returned word.
    pvld_d[0]   = mem_rd_out;
    pdim_d[0]   = dim_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pdim_d[i] = pdim_q[i-1];
    end
    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          addr_d      = cand_base_in;
          count_d     = cand_count_in;
          idx_d       = '0;
          dim_d       = '0;
          tmr_d       = '0;
          best_idx_d  = '0;
          best_dist_d = DistAllOnes[WIDTH-1:0];
          found_d     = 1'b0;
          error_d     = 1'b0;
        end
      end
      StFetch: begin
        addr_d = addr_q + ADDR_W'(1);
        dim_d  = dim_last ? '0 : dim_q + DimW'(1);
        tmr_d  = '0;
      end
      StDrain: begin
        tmr_d = tmr_q + TmrW'(1);
        if (dist_valid) begin
          found_d = 1'b1;
          // Strict compare keeps the earlier index on ties.
          if (dist_val < best_dist_q) begin
            best_dist_d = dist_val;
            best_idx_d  = idx_q;
          end
          idx_d = idx_q + CNT_W'(1);
          tmr_d = '0;
        end else if (tmr_expired) begin
          error_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      addr_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      best_idx_q  <= '0;
      best_dist_q <= DistAllOnes[WIDTH-1:0];
      dim_q       <= '0;
      tmr_q       <= '0;
      found_q     <= 1'b0;
      error_q     <= 1'b0;
      pvld_q      <= '0;
      pdim_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      best_idx_q  <= best_idx_d;
      best_dist_q <= best_dist_d;
      dim_q       <= dim_d;
      tmr_q       <= tmr_d;
      found_q     <= found_d;
      error_q     <= error_d;
      pvld_q      <= pvld_d;
      pdim_q      <= pdim_d;
    end
  end

  always_comb begin
    dv_in   = '0;
    vpos_in = '0;
    if (pvld_q[MEM_LAT-1]) begin
      dv_in[pdim_q[MEM_LAT-1]]   = 1'b1;
      vpos_in[pdim_q[MEM_LAT-1]] = mem_data_in;
    end
  end

  nearest_search_ctrl_dist #(
    .DIM   (DIM),
    .WIDTH (WIDTH)
  ) u_dist (
    .clk_in         (clk_in),
    .rst_in         (rst_sync_q),
    .data_valid_in  (dv_in),
    .vertex_pos_in  (vpos_in),
    .query_pos_in   (query_pos_in),
    .data_valid_out (dist_valid),
    .dist_out       (dist_val)
  );

  assign mem_addr_out  = addr_q;
  assign found_out     = found_q;
  assign best_dist_out = best_dist_q;
  assign best_idx_out  = best_idx_q;
  assign error_out     = error_q;

endmodule

// File: tb/tb_nearest_search_ctrl.sv
// Directed bench for nearest_search_ctrl: memory model with fixed read latency,
// read/done monitors, and hand-computed expectations checked by immediate assertions.
`timescale 1ns / 1ps
module tb_nearest_search_ctrl;

  logic               clk = 1'b0;
  logic               rst_in = 1'b1;
  logic               start_in = 1'b0;
  logic [15:0]        cand_base_in = '0;
  logic [7:0]         cand_count_in = '0;
  logic [8:0][31:0]   query_pos_in;
  logic               mem_rd_out;
  logic [15:0]        mem_addr_out;
  logic [31:0]        mem_data_in;
  logic               busy_out, done_out, found_out, error_out;
  logic [31:0]        best_dist_out;
  logic [7:0]         best_idx_out;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int done_count = 0;
  logic [15:0] addr_log[$];

  logic [31:0] mem [0:65535];
  logic [1:0][15:0] p_addr;

  always #5 clk = ~clk;

  nearest_search_ctrl dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .cand_base_in  (cand_base_in),
    .cand_count_in (cand_count_in),
    .query_pos_in  (query_pos_in),
    .mem_rd_out    (mem_rd_out),
    .mem_addr_out  (mem_addr_out),
    .mem_data_in   (mem_data_in),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .found_out     (found_out),
    .best_dist_out (best_dist_out),
    .best_idx_out  (best_idx_out),
    .error_out     (error_out)
  );

  // Two-cycle read latency memory.
  always @(posedge clk) begin
    p_addr[0] <= mem_addr_out;
    p_addr[1] <= p_addr[0];
  end
  assign mem_data_in = mem[p_addr[1]];

  always @(posedge clk) begin
    if (mem_rd_out) begin
      rd_count <= rd_count + 1;
      addr_log.push_back(mem_addr_out);
    end
    if (done_out) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_cand(input logic [15:0] base, input int k, input logic [8:0][31:0] v);
    for (int d = 0; d < 9; d++) mem[base + 16'(k * 9 + d)] = v[d];
  endtask

  task automatic clear_log();
    @(negedge clk);
    rd_count   = 0;
    done_count = 0;
    addr_log.delete();
  endtask

  task automatic start(input logic [15:0] base, input logic [7:0] cnt);
    @(negedge clk);
    start_in      = 1'b1;
    cand_base_in  = base;
    cand_count_in = cnt;
    @(negedge clk);
    start_in      = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (!done_out && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 1000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_addrs(input string tag, input logic [15:0] base, input int n);
    int bad = 0;
    for (int i = 0; i < addr_log.size(); i++)
      if (addr_log[i] !== base + 16'(i)) bad++;
    chk(tag, 64'(bad), 64'd0);
    chk({tag, "_n"}, 64'(addr_log.size()), 64'(n));
  endtask

  logic [8:0][31:0] c0, c1, c2;

  initial begin
    query_pos_in = {32'd18, 32'd53, 32'd1, 32'd103, 32'd17, 32'd99, 32'd2, 32'd67, 32'd23};

    // Reset state
    #1 rst_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_found", 64'(found_out), 64'd0);
    chk("rst_error", 64'(error_out), 64'd0);
    chk("rst_rd", 64'(mem_rd_out), 64'd0);
    chk("rst_addr", 64'(mem_addr_out), 64'd0);
    chk("rst_idx", 64'(best_idx_out), 64'd0);
    chk("rst_dist", 64'(best_dist_out), 64'hFFFF_FFFF);
    rst_in = 1'b1;
    repeat (2) @(negedge clk);

    // V1: single candidate
    c0 = {32'd19, 32'd39, 32'd20, 32'd12, 32'd7, 32'd82, 32'd231, 32'd123, 32'd89};
    load_cand(16'h0100, 0, c0);
    clear_log();
    start(16'h0100, 8'd1);
    run_to_done("v1_done_seen");
    chk("v1_dist", 64'(best_dist_out), 64'd69161);
    chk("v1_idx", 64'(best_idx_out), 64'd0);
    chk("v1_found", 64'(found_out), 64'd1);
    chk("v1_done_cnt", 64'(done_count), 64'd1);
    chk("v1_busy", 64'(busy_out), 64'd0);
    chk_addrs("v1_addr", 16'h0100, 9);

    // V2: query+1 (dist 9), query, query -> tie keeps idx 1
    for (int d = 0; d < 9; d++) c0[d] = query_pos_in[d] + 32'd1;
    load_cand(16'h0200, 0, c0);
    load_cand(16'h0200, 1, query_pos_in);
    load_cand(16'h0200, 2, query_pos_in);
    clear_log();
    start(16'h0200, 8'd3);
    run_to_done("v2_done_seen");
    chk("v2_dist", 64'(best_dist_out), 64'd0);
    chk("v2_idx", 64'(best_idx_out), 64'd1);
    chk_addrs("v2_addr", 16'h0200, 27);

    // V3: zero candidates
    clear_log();
    start(16'h0400, 8'd0);
    chk("v3_done_next", 64'(done_out), 64'd1);
    @(negedge clk);
    chk("v3_done_once", 64'(done_out), 64'd0);
    chk("v3_found", 64'(found_out), 64'd0);
    chk("v3_dist", 64'(best_dist_out), 64'hFFFF_FFFF);
    chk("v3_reads", 64'(rd_count), 64'd0);

    // V4: address wrap; cand0 dist 16, cand1 dist 9
    c0 = query_pos_in; c0[0] = c0[0] + 32'd4;
    c1 = query_pos_in; c1[3] = c1[3] - 32'd3;
    load_cand(16'hFFFC, 0, c0);
    load_cand(16'hFFFC, 1, c1);
    clear_log();
    start(16'hFFFC, 8'd2);
    run_to_done("v4_done_seen");
    chk("v4_dist", 64'(best_dist_out), 64'd9);
    chk("v4_idx", 64'(best_idx_out), 64'd1);
    chk_addrs("v4_addr", 16'hFFFC, 18);
    chk("v4_last_addr", 64'(addr_log[17]), 64'h000D);

    // V5: start pulsed during FETCH is ignored; cand0 dist 1, cand1 dist 4
    c0 = query_pos_in; c0[0] = c0[0] + 32'd1;
    c1 = query_pos_in; c1[8] = c1[8] + 32'd2;
    load_cand(16'h0300, 0, c0);
    load_cand(16'h0300, 1, c1);
    clear_log();
    start(16'h0300, 8'd2);
    @(negedge clk);
    start_in = 1'b1; cand_base_in = 16'h0500; cand_count_in = 8'd1;
    @(negedge clk);
    start_in = 1'b0;
    run_to_done("v5_done_seen");
    chk("v5_dist", 64'(best_dist_out), 64'd1);
    chk("v5_idx", 64'(best_idx_out), 64'd0);
    chk("v5_done_cnt", 64'(done_count), 64'd1);
    chk_addrs("v5_addr", 16'h0300, 18);

    // V6: reset during DRAIN
    clear_log();
    start(16'h0100, 8'd1);
    for (int n = 0; n < 100 && rd_count < 9; n++) @(negedge clk);
    chk("v6_in_drain", 64'({busy_out, mem_rd_out}), 64'b10);
    #2 rst_in = 1'b0;
    #1;
    chk("v6_busy", 64'(busy_out), 64'd0);
    chk("v6_found", 64'(found_out), 64'd0);
    chk("v6_dist", 64'(best_dist_out), 64'hFFFF_FFFF);
    chk("v6_addr", 64'(mem_addr_out), 64'd0);
    repeat (5) @(negedge clk);
    chk("v6_no_done", 64'(done_count), 64'd0);
    chk("v6_reads", 64'(rd_count), 64'd9);
    rst_in = 1'b1;
    repeat (2) @(negedge clk);

    // V7: distance result suppressed -> timeout after 64 DRAIN cycles
    force dut.dist_valid = 1'b0;
    clear_log();
    start(16'h0100, 8'd1);
    for (int n = 0; n < 100 && rd_count < 9; n++) @(negedge clk);
    begin
      int n = 0;
      while (!done_out && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("v7_drain_cycles", 64'(n), 64'd64);
    end
    chk("v7_done", 64'(done_out), 64'd1);
    chk("v7_error", 64'(error_out), 64'd1);
    chk("v7_found", 64'(found_out), 64'd0);
    release dut.dist_valid;
    repeat (3) @(negedge clk);
    chk("v7_error_sticky", 64'(error_out), 64'd1);
    start(16'h0400, 8'd0);
    chk("v7_error_clr", 64'(error_out), 64'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
